// File: rtl/main_memory_responder.sv
// Block-organised backing memory serving dcache read/write and icache read misses.
// Define MEMRESP_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed D-over-I priority.
module main_memory_responder #(
  parameter int unsigned BLOCK_W      = 128,
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned DEPTH_BLOCKS = 256,
  parameter int unsigned LATENCY      = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDRESS,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDRESS,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT
);

  localparam int unsigned IDX_W = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_i_q, grant_i_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
  logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;

  logic [BLOCK_W-1:0] mem [DEPTH_BLOCKS];
  logic [BLOCK_W-1:0] mem_rd;
  logic               mem_we;
  logic               d_req;
  logic               grant_i_sel;
  logic               unused_addr_bits;

  assign d_req            = D_READ | D_WRITE;
  assign mem_rd           = mem[idx_q];
  assign unused_addr_bits = ^{D_ADDRESS, I_ADDRESS};

`ifdef MEMRESP_ROUND_ROBIN_EN
  // High when the last completed transaction served D, so I wins the next tie.
  logic rr_prefer_i_q, rr_prefer_i_d;

  always_comb begin
    rr_prefer_i_d = rr_prefer_i_q;
    if (state_q == ST_DONE) begin
      rr_prefer_i_d = ~grant_i_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rr_prefer_i_q <= 1'b0;
    end else begin
      rr_prefer_i_q <= rr_prefer_i_d;
    end
  end

  assign grant_i_sel = I_READ & (~d_req | rr_prefer_i_q);
`else
  assign grant_i_sel = I_READ & ~d_req;
`endif

  // Next-state and datapath: inputs are captured only at grant.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_i_d = grant_i_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_req | I_READ) begin
          grant_i_d = grant_i_sel;
          idx_d     = grant_i_sel ? I_ADDRESS[IDX_W-1:0] : D_ADDRESS[IDX_W-1:0];
          wr_d      = ~grant_i_sel & D_WRITE;
          wdata_d   = D_WRITEDATA;
          cnt_d     = '0;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = ST_DONE;
          if (wr_q) begin
            mem_we = 1'b1;
          end else if (grant_i_q) begin
            i_rdata_d = mem_rd;
          end else begin
            d_rdata_d = mem_rd;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      grant_i_q <= 1'b0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_i_q <= grant_i_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
    end
  end

  // Backing storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign D_READDATA = d_rdata_q;
  assign I_READDATA = i_rdata_q;

  // Stall drops only in the DONE cycle of the port's own transaction.
  assign D_BUSYWAIT = ~RESET & d_req  & ~((state_q == ST_DONE) & ~grant_i_q);
  assign I_BUSYWAIT = ~RESET & I_READ & ~((state_q == ST_DONE) &  grant_i_q);

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed-vector bench for main_memory_responder (LATENCY=5, DEPTH_BLOCKS=256).
module tb_main_memory_responder;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         D_READ = 1'b0;
  logic         D_WRITE = 1'b0;
  logic [27:0]  D_ADDRESS = '0;
  logic [127:0] D_WRITEDATA = '0;
  logic [127:0] D_READDATA;
  logic         D_BUSYWAIT;
  logic         I_READ = 1'b0;
  logic [27:0]  I_ADDRESS = '0;
  logic [127:0] I_READDATA;
  logic         I_BUSYWAIT;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [127:0] BLK1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] BLKA5 = {16{8'hA5}};
  localparam logic [127:0] BLK20 = 128'h20202020_11111111_22222222_33333333;
  localparam logic [127:0] BLK30 = 128'h30303030_44444444_55555555_66666666;
  localparam logic [127:0] BLK40 = 128'h40404040_77777777_88888888_99999999;
  localparam logic [127:0] BLK50 = 128'h50505050_AAAAAAAA_BBBBBBBB_CCCCCCCC;
  localparam logic [127:0] BLK7  = 128'h07070707_12345678_9ABCDEF0_0FEDCBA9;

  main_memory_responder #(
    .BLOCK_W(128), .ADDR_W(28), .DEPTH_BLOCKS(256), .LATENCY(5)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS),
    .D_WRITEDATA(D_WRITEDATA), .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start of a cycle: just after the active edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Present a dcache request at the current cycle, count busy cycles, capture data in DONE.
  task automatic run_d(input logic rd, input logic wr, input logic [27:0] a,
                       input logic [127:0] wd, output int busy, output logic [127:0] rdat);
    bit done;
    D_READ = rd; D_WRITE = wr; D_ADDRESS = a; D_WRITEDATA = wd;
    busy = 0;
    done = 1'b0;
    rdat = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (D_BUSYWAIT) busy++;
      else begin
        done = 1'b1;
        rdat = D_READDATA;
      end
    end
    next_cycle();
    D_READ = 1'b0; D_WRITE = 1'b0;
  endtask

  task automatic run_i(input logic [27:0] a, output int busy, output logic [127:0] rdat);
    bit done;
    I_READ = 1'b1; I_ADDRESS = a;
    busy = 0;
    done = 1'b0;
    rdat = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (I_BUSYWAIT) busy++;
      else begin
        done = 1'b1;
        rdat = I_READDATA;
      end
    end
    next_cycle();
    I_READ = 1'b0;
  endtask

  initial begin
    int bd, bi;
    logic [127:0] rd_d, rd_i, prev;

    // Reset with requests held: stalls and read registers must be zero.
    D_READ = 1'b1; I_READ = 1'b1;
    #2;
    chk("rst_d_busy", 128'(D_BUSYWAIT), 128'd0);
    chk("rst_i_busy", 128'(I_BUSYWAIT), 128'd0);
    chk("rst_d_rdata", D_READDATA, 128'd0);
    chk("rst_i_rdata", I_READDATA, 128'd0);
    D_READ = 1'b0; I_READ = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    next_cycle();

    // Test 1: write then read back
    run_d(1'b0, 1'b1, 28'h10, BLK1, bd, rd_d);
    chk("t1_wr_busy", 128'(bd), 128'd6);
    run_d(1'b1, 1'b0, 28'h10, '0, bd, rd_d);
    chk("t1_rd_busy", 128'(bd), 128'd6);
    chk("t1_rd_data", rd_d, BLK1);

    // Test 2: icache read of the same block
    run_i(28'h10, bi, rd_i);
    chk("t2_i_busy", 128'(bi), 128'd6);
    chk("t2_i_data", rd_i, BLK1);
    chk("t2_d_hold", D_READDATA, BLK1);

    // Test 3: simultaneous requests, D wins in default build
    run_d(1'b0, 1'b1, 28'h20, BLK20, bd, rd_d);
    run_d(1'b0, 1'b1, 28'h30, BLK30, bd, rd_d);
    run_i(28'h00, bi, rd_i);
    fork
      run_d(1'b1, 1'b0, 28'h20, '0, bd, rd_d);
      run_i(28'h30, bi, rd_i);
    join
`ifdef MEMRESP_ROUND_ROBIN_EN
    // Last completion before the tie was I, so D is preferred here too.
    chk("t3_d_busy", 128'(bd), 128'd6);
    chk("t3_i_busy", 128'(bi), 128'd13);
`else
    chk("t3_d_busy", 128'(bd), 128'd6);
    chk("t3_i_busy", 128'(bi), 128'd13);
`endif
    chk("t3_d_data", rd_d, BLK20);
    chk("t3_i_data", rd_i, BLK30);

    // Test 4: after a D completion, tie again
    run_d(1'b1, 1'b0, 28'h10, '0, bd, rd_d);
    fork
      run_d(1'b1, 1'b0, 28'h30, '0, bd, rd_d);
      run_i(28'h20, bi, rd_i);
    join
`ifdef MEMRESP_ROUND_ROBIN_EN
    chk("t4_i_busy", 128'(bi), 128'd6);
    chk("t4_d_busy", 128'(bd), 128'd13);
`else
    chk("t4_d_busy", 128'(bd), 128'd6);
    chk("t4_i_busy", 128'(bi), 128'd13);
`endif
    chk("t4_d_data", rd_d, BLK30);
    chk("t4_i_data", rd_i, BLK20);

    // Test 5: index aliasing
    run_d(1'b0, 1'b1, 28'h3, BLKA5, bd, rd_d);
    run_d(1'b1, 1'b0, 28'd259, '0, bd, rd_d);
    chk("t5_alias", rd_d, BLKA5);

    // Withdrawn write still commits; later input changes are ignored
    D_WRITE = 1'b1; D_ADDRESS = 28'h40; D_WRITEDATA = BLK40;
    next_cycle();
    next_cycle();
    D_WRITE = 1'b0; D_WRITEDATA = '1; D_ADDRESS = 28'h41;
    repeat (8) next_cycle();
    run_d(1'b1, 1'b0, 28'h40, '0, bd, rd_d);
    chk("wd_commit", rd_d, BLK40);

    // Read and write together: write wins, D_READDATA untouched
    prev = D_READDATA;
    run_d(1'b1, 1'b1, 28'h50, BLK50, bd, rd_d);
    chk("rw_busy", 128'(bd), 128'd6);
    chk("rw_hold", rd_d, prev);
    run_d(1'b1, 1'b0, 28'h50, '0, bd, rd_d);
    chk("rw_data", rd_d, BLK50);

    // Test 6: reset aborts a write in flight
    run_d(1'b0, 1'b1, 28'h7, '0, bd, rd_d);
    D_WRITE = 1'b1; D_ADDRESS = 28'h7; D_WRITEDATA = BLK7;
    repeat (3) next_cycle();
    RESET = 1'b1;
    #1;
    chk("t6_d_busy", 128'(D_BUSYWAIT), 128'd0);
    chk("t6_d_rdata", D_READDATA, 128'd0);
    chk("t6_i_rdata", I_READDATA, 128'd0);
    D_WRITE = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    next_cycle();
    run_d(1'b1, 1'b0, 28'h7, '0, bd, rd_d);
    chk("t6_no_commit", rd_d, 128'd0);
    run_d(1'b0, 1'b1, 28'h7, BLK7, bd, rd_d);
    chk("t6_rewr_busy", 128'(bd), 128'd6);
    run_d(1'b1, 1'b0, 28'h7, '0, bd, rd_d);
    chk("t6_rewr_data", rd_d, BLK7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
